// File: rtl/shift_accumulate.sv
// shift_accumulate: one rotation-mode CORDIC micro-rotation per clock.
//
// Each sample of (x, y, z) at stage i is rotated by +/-atan(2^-i). The
// direction comes from the sign of the residual angle z. The result is
// registered, so the latency is exactly one clock.
//
// Angle scale: 1.0 rad = 1024 LSB. No CORDIC gain compensation is applied.
// All arithmetic is 32-bit and wraps modulo 2^32.
//
// Handshake: in_valid qualifies x/y/z/i at a rising edge. There is no ready
// signal, so a result is produced for every valid cycle. out_valid is high
// for exactly the cycle after each accepted sample. While in_valid is low,
// out_valid drops and x_out/y_out/z_out keep their last result.
//
// Ports:
//   clk       in   1  clock, rising edge
//   rst_n     in   1  asynchronous active-low reset
//   x, y      in  32  signed coordinates
//   z         in  32  signed residual angle
//   i         in   4  stage index 0..15 (shift amount / table entry)
//   in_valid  in   1  input qualifier
//   x_out     out 32  registered X result
//   y_out     out 32  registered Y result
//   z_out     out 32  registered residual angle
//   out_valid out  1  registered result qualifier
module shift_accumulate (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic [31:0] z,
  input  logic [3:0]  i,
  input  logic        in_valid,
  output logic [31:0] x_out,
  output logic [31:0] y_out,
  output logic [31:0] z_out,
  output logic        out_valid
);

  logic [31:0] x_out_q, x_out_d;
  logic [31:0] y_out_q, y_out_d;
  logic [31:0] z_out_q, z_out_d;
  logic        out_valid_q, out_valid_d;

  logic signed [31:0] x_s;
  logic signed [31:0] y_s;
  logic [31:0]        x_sh;
  logic [31:0]        y_sh;
  logic [31:0]        atan_val;
  logic               rot_neg;

  // floor(atan(2^-i) * 1024). Entries for stages 10 and above are zero, so
  // the angle passes through unchanged there.
  always_comb begin
    atan_val = 32'd0;
    case (i)
      4'd0:    atan_val = 32'd804;
      4'd1:    atan_val = 32'd474;
      4'd2:    atan_val = 32'd250;
      4'd3:    atan_val = 32'd127;
      4'd4:    atan_val = 32'd63;
      4'd5:    atan_val = 32'd31;
      4'd6:    atan_val = 32'd15;
      4'd7:    atan_val = 32'd7;
      4'd8:    atan_val = 32'd3;
      4'd9:    atan_val = 32'd1;
      default: atan_val = 32'd0;
    endcase
  end

  // Arithmetic shifts, so negative values round toward minus infinity.
  assign x_s     = x;
  assign y_s     = y;
  assign x_sh    = x_s >>> i;
  assign y_sh    = y_s >>> i;
  // A residual angle of exactly zero counts as a positive rotation.
  assign rot_neg = z[31];

  always_comb begin
    x_out_d     = x_out_q;
    y_out_d     = y_out_q;
    z_out_d     = z_out_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      out_valid_d = 1'b1;
      if (rot_neg) begin
        x_out_d = x + y_sh;
        y_out_d = y - x_sh;
        z_out_d = z + atan_val;
      end else begin
        x_out_d = x - y_sh;
        y_out_d = y + x_sh;
        z_out_d = z - atan_val;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_out_q     <= 32'd0;
      y_out_q     <= 32'd0;
      z_out_q     <= 32'd0;
      out_valid_q <= 1'b0;
    end else begin
      x_out_q     <= x_out_d;
      y_out_q     <= y_out_d;
      z_out_q     <= z_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign x_out     = x_out_q;
  assign y_out     = y_out_q;
  assign z_out     = z_out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_shift_accumulate.sv
// tb_shift_accumulate: testbench for shift_accumulate.
//
// The bench starts with directed vectors whose expected values are worked
// out by hand, then runs randomized traffic. The random results are
// predicted by a reference model that uses floor division and wide
// integers. A monitor compares every output against the expected queue.
module tb_shift_accumulate;

  logic        clk;
  logic        rst_n;
  logic [31:0] x;
  logic [31:0] y;
  logic [31:0] z;
  logic [3:0]  i;
  logic        in_valid;
  logic [31:0] x_out;
  logic [31:0] y_out;
  logic [31:0] z_out;
  logic        out_valid;

  logic [95:0] exp_q[$];
  logic [95:0] held_exp;
  int          n_checks;
  int          n_pass;
  bit          stim_done;

  int atan_tab[16] = '{804, 474, 250, 127, 63, 31, 15, 7, 3, 1, 0, 0, 0, 0, 0, 0};

  shift_accumulate dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .x         (x),
    .y         (y),
    .z         (z),
    .i         (i),
    .in_valid  (in_valid),
    .x_out     (x_out),
    .y_out     (y_out),
    .z_out     (z_out),
    .out_valid (out_valid)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic longint floor_div(input longint a, input longint d);
    longint q;
    q = a / d;
    if ((a % d != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic logic [95:0] model(input logic [31:0] xv, input logic [31:0] yv,
                                        input logic [31:0] zv, input logic [3:0] iv);
    longint xs, ys, zs, d, xn, yn, zn;
    logic [31:0] xr, yr, zr;
    xs = longint'($signed(xv));
    ys = longint'($signed(yv));
    zs = longint'($signed(zv));
    d  = longint'(1) << iv;
    if (zs >= 0) begin
      xn = xs - floor_div(ys, d);
      yn = ys + floor_div(xs, d);
      zn = zs - atan_tab[iv];
    end else begin
      xn = xs + floor_div(ys, d);
      yn = ys - floor_div(xs, d);
      zn = zs + atan_tab[iv];
    end
    xr = xn[31:0];
    yr = yn[31:0];
    zr = zn[31:0];
    return {xr, yr, zr};
  endfunction

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got x=%0d y=%0d z=%0d, expected x=%0d y=%0d z=%0d", name,
                  $signed(act[95:64]), $signed(act[63:32]), $signed(act[31:0]),
                  $signed(req[95:64]), $signed(req[63:32]), $signed(req[31:0]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [31:0] xv, input logic [31:0] yv, input logic [31:0] zv,
                      input logic [3:0] iv, input bit v, input bit use_model,
                      input logic [95:0] exp_const);
    @(posedge clk);
    #1;
    x = xv; y = yv; z = zv; i = iv; in_valid = v;
    if (v) exp_q.push_back(use_model ? model(xv, yv, zv, iv) : exp_const);
  endtask

  task automatic idle();
    send($urandom, $urandom, $urandom, 4'($urandom_range(0, 15)), 1'b0, 1'b0, 96'd0);
  endtask

  // Assert reset between edges and check that the outputs clear at once.
  task automatic pulse_reset(input string name);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    held_exp = 96'd0;
    #1;
    check(name, {x_out, y_out, z_out}, 96'd0);
    n_checks++;
    if (out_valid === 1'b0) n_pass++;
    else $display("FAIL %s_valid: got out_valid=%b, expected 0", name, out_valid);
    in_valid = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_hold", {x_out, y_out, z_out}, 96'd0);
      n_checks++;
      if (out_valid === 1'b0) n_pass++;
      else $display("FAIL reset_valid: got out_valid=%b, expected 0", out_valid);
    end else if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_output: got out_valid=1, expected no pending result");
      end else begin
        held_exp = exp_q.pop_front();
        check("result", {x_out, y_out, z_out}, held_exp);
      end
    end else begin
      check("idle_hold", {x_out, y_out, z_out}, held_exp);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_checks  = 0;
    n_pass    = 0;
    stim_done = 1'b0;
    held_exp  = 96'd0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    x = 32'd0; y = 32'd0; z = 32'd0; i = 4'd0;
    #1;
    check("por_outputs", {x_out, y_out, z_out}, 96'd0);
    n_checks++;
    if (out_valid === 1'b0) n_pass++;
    else $display("FAIL por_valid: got out_valid=%b, expected 0", out_valid);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;

    // Directed vectors with hand-computed results. The first two are
    // streamed back to back, then the bus idles and reset is pulsed.
    send(32'd1000, 32'd0, 32'd100, 4'd0, 1'b1, 1'b0,
         {32'd1000, 32'd1000, -32'sd704});
    send(32'd1000, 32'd1000, -32'sd704, 4'd1, 1'b1, 1'b0,
         {32'd1500, 32'd500, -32'sd230});
    idle();
    idle();
    pulse_reset("stream_reset");
    send(-32'sd16, 32'd8, 32'd0, 4'd3, 1'b1, 1'b0,
         {-32'sd17, 32'd6, -32'sd127});
    send(32'd4096, 32'd4096, 32'd5, 4'd12, 1'b1, 1'b0,
         {32'd4095, 32'd4097, 32'd5});
    send(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd0, 4'd0, 1'b1, 1'b0,
         {32'd0, 32'hFFFF_FFFE, -32'sd804});
    idle();

    // Randomized traffic: random valid gaps, stages and operand widths.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] xv, yv, zv;
      case ($urandom_range(0, 3))
        0:       begin xv = $urandom; yv = $urandom; zv = $urandom; end
        1:       begin xv = 32'($signed(16'($urandom))); yv = 32'($signed(16'($urandom)));
                       zv = 32'($signed(12'($urandom))); end
        2:       begin xv = ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
                       yv = ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
                       zv = ($urandom_range(0, 1) != 0) ? 32'd0 : 32'hFFFF_FFFF; end
        default: begin xv = $urandom_range(0, 64) - 32; yv = $urandom_range(0, 64) - 32;
                       zv = $urandom_range(0, 4) - 2; end
      endcase
      send(xv, yv, zv, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), 1'b1, 96'd0);
    end

    // A sample launched just before reset must be discarded.
    send(32'd123, 32'd456, 32'd789, 4'd2, 1'b1, 1'b1, 96'd0);
    pulse_reset("inflight_reset");
    send(32'd50, 32'd60, -32'sd70, 4'd5, 1'b1, 1'b1, 96'd0);
    idle();

    // Drain with a bounded wait.
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending results, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_accumulate.md
SHIFT_ACCUMULATE -- requirements
Module: shift_accumulate

Interface
REQ-001 The block SHALL have no parameters; stage index is a port, the arctangent table is internal.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 x  input  32  signed two's-complement X coordinate in.
REQ-005 y  input  32  signed two's-complement Y coordinate in.
REQ-006 z  input  32  signed residual angle in; 1.0 rad = 1024 LSB.
REQ-007 i  input  4  CORDIC stage index 0..15; selects shift amount and table entry.
REQ-008 in_valid  input  1  qualifies x/y/z/i this cycle.
REQ-009 x_out  output  32  registered signed X result.
REQ-010 y_out  output  32  registered signed Y result.
REQ-011 z_out  output  32  registered signed residual angle result.
REQ-012 out_valid  output  1  registered; high when x_out/y_out/z_out hold a result.

Function
REQ-013 The block SHALL implement one rotation-mode CORDIC micro-rotation with a constant latency of 1 clock.
REQ-014 The arctangent table SHALL be the constant set atan[0..15] = 804, 474, 250, 127, 63, 31, 15, 7, 3, 1, 0, 0, 0, 0, 0, 0 (floor(atan(2^-i)*1024)).
REQ-015 Direction SHALL be taken from z[31]: z[31]=0 (z>=0, including 0) is positive rotation; z[31]=1 is negative rotation.
REQ-016 Positive rotation SHALL compute x_out = x - (y>>>i), y_out = y + (x>>>i), z_out = z - atan[i].
REQ-017 Negative rotation SHALL compute x_out = x + (y>>>i), y_out = y - (x>>>i), z_out = z + atan[i].
REQ-018 Shifts SHALL be arithmetic (sign-extending), so negative values round toward minus infinity (-16>>>3 = -2).
REQ-019 All additions/subtractions SHALL be 32-bit, wrapping modulo 2^32 with no saturation and no overflow flag.
REQ-020 No gain (K) compensation SHALL be applied; the caller pre-scales.
REQ-021 On a rising edge with in_valid=1, outputs SHALL load the results of REQ-016/017 using x, y, z, i sampled at that edge, and out_valid SHALL become 1.
REQ-022 On a rising edge with in_valid=0, out_valid SHALL become 0 and x_out/y_out/z_out SHALL hold their previous values.
REQ-023 i MAY change every cycle; each sample uses the i presented with it.
REQ-024 For i>=10 the angle path SHALL pass z through unchanged (atan=0) while x/y still rotate.
REQ-025 Back-to-back in_valid=1 cycles SHALL yield one result per cycle, in order, without stall or backpressure.

Reset
REQ-026 While rst_n=0, x_out, y_out, z_out SHALL be 0 and out_valid SHALL be 0, immediately and independent of clk.
REQ-027 After rst_n deasserts, the first rising edge SHALL behave per REQ-021/022; a transaction in flight at reset assertion SHALL be discarded.

Verification
REQ-028 i=0, x=1000, y=0, z=100, in_valid=1 -> next edge: x_out=1000, y_out=1000, z_out=-704, out_valid=1.
REQ-029 i=1, x=1000, y=1000, z=-704 -> x_out=1500, y_out=500, z_out=-230.
REQ-030 i=3, x=-16, y=8, z=0 (zero counts as positive) -> x_out=-17, y_out=6, z_out=-127.
REQ-031 i=12, x=4096, y=4096, z=5 -> x_out=4095, y_out=4097, z_out=5 (atan=0).
REQ-032 Wrap: i=0, x=y=32'h7FFFFFFF, z=0 -> x_out=0, y_out=32'hFFFFFFFE, z_out=-804.
REQ-033 Stream REQ-028 then REQ-029 on consecutive cycles, then in_valid=0, then pulse rst_n low between edges -> results on consecutive cycles, outputs held while in_valid=0, all outputs 0 and out_valid=0 immediately at reset.
